// File: rtl/output_uart_tx_if.sv
// Core OUT-port handshake: the core drives the request and data, and the UART side
// drives back the FIFO-full stall signal.
interface output_uart_tx_if #(
    parameter int REG_W = 32
);
    logic             out_req;
    logic [REG_W-1:0] out_data;
    logic             out_busy;

    modport master (output out_req, output out_data, input out_busy);
    modport slave  (input out_req, input out_data, output out_busy);
endinterface

// File: rtl/output_uart_tx.sv
// OUT-port sink: captures each OUT byte on the request's falling edge, buffers it in a FIFO
// and shifts it out on txd as 8N1 UART, LSB first. It stalls the core while the FIFO is full.
module output_uart_tx #(
    parameter int CLK_PER_BIT     = 868,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int REG_W           = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    output_uart_tx_if.slave          bus,
    output logic                     txd,
    output logic                     tx_idle,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int TW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic          req_d_r;
    logic [7:0]    hold_r;
    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          busy_r, ovf_r, txd_r, tx_idle_r;
    state_t        state_r, state_nxt;
    logic [TW-1:0] tmr_r, tmr_nxt;
    logic [2:0]    idx_r, idx_nxt;
    logic [7:0]    shreg_r, shreg_nxt;
    logic          txd_nxt, pop_s;
    logic          commit_s, full_s, wr_en_s;
    logic          data_unused_s;

    // Only the low byte of the OUT data is ever transmitted.
    assign data_unused_s = ^bus.out_data[REG_W-1:8];

    assign commit_s = req_d_r & ~bus.out_req;
    assign full_s   = (count_r == FULL_CNT);
    assign wr_en_s  = commit_s & ~full_s;

    // Track the request and keep the last data seen while it is high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_d_r <= 1'b0;
            hold_r  <= 8'h00;
        end else begin
            req_d_r <= bus.out_req;
            if (bus.out_req) hold_r <= bus.out_data[7:0];
        end
    end

    // FIFO storage needs no reset; entries are only read once they have been written.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= hold_r;
    end

    // Next occupancy. A commit and a pop in the same cycle cancel out.
    always_comb begin
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and the busy/overflow flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            busy_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_nxt_s;
            busy_r  <= (count_nxt_s == FULL_CNT);
            if (commit_s && full_s) ovf_r <= 1'b1;
        end
    end

    // Serializer next state. txd is derived from the next state so that the register
    // changes on the same edge as the state.
    always_comb begin
        state_nxt = state_r;
        tmr_nxt   = tmr_r;
        idx_nxt   = idx_r;
        shreg_nxt = shreg_r;
        pop_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                tmr_nxt = TW'(0);
                if (count_r != CW'(0)) begin
                    pop_s     = 1'b1;
                    shreg_nxt = mem_r[rd_ptr_r];
                    state_nxt = S_START;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (tmr_r == TMR_LAST) begin
                    tmr_nxt   = TW'(0);
                    idx_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    tmr_nxt = tmr_r + TW'(1);
                end
            end
            S_DATA: begin
                if (tmr_r == TMR_LAST) begin
                    tmr_nxt = TW'(0);
                    if (idx_r == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt = idx_r + 3'd1;
                    end
                end else begin
                    tmr_nxt = tmr_r + TW'(1);
                end
            end
            S_STOP: begin
                if (tmr_r == TMR_LAST) begin
                    tmr_nxt   = TW'(0);
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr_r + TW'(1);
                end
            end
            default: begin
                tmr_nxt   = TW'(0);
                state_nxt = S_IDLE;
            end
        endcase
        case (state_nxt)
            S_START: txd_nxt = 1'b0;
            S_DATA:  txd_nxt = shreg_nxt[idx_nxt];
            default: txd_nxt = 1'b1;
        endcase
    end

    // Serializer state and registered line/idle outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            tmr_r     <= TW'(0);
            idx_r     <= 3'd0;
            shreg_r   <= 8'h00;
            txd_r     <= 1'b1;
            tx_idle_r <= 1'b1;
        end else begin
            state_r   <= state_nxt;
            tmr_r     <= tmr_nxt;
            idx_r     <= idx_nxt;
            shreg_r   <= shreg_nxt;
            txd_r     <= txd_nxt;
            tx_idle_r <= (count_nxt_s == CW'(0)) && (state_nxt == S_IDLE);
        end
    end

    assign bus.out_busy = busy_r;
    assign txd          = txd_r;
    assign tx_idle      = tx_idle_r;
    assign fifo_count   = count_r;
    assign overflow     = ovf_r;
endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: OUT commands push expected bytes to a queue, and a txd decoder
// pops and compares each received frame.
module tb_output_uart_tx;
    localparam int CPB   = 4;
    localparam int FDL   = 2;
    localparam int REG_W = 32;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           txd, tx_idle, overflow;
    logic [FDL:0]   fifo_count;
    logic [7:0]     sb [$];
    logic           mon_en = 1'b0;
    int             n_cmp = 0;
    int             n_err = 0;
    int             peak;
    int             cnt;

    output_uart_tx_if #(.REG_W(REG_W)) bus ();

    output_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG2(FDL), .REG_W(REG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .txd        (txd),
        .tx_idle    (tx_idle),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One OUT: request high for n cycles, d_first until the last cycle, then d_last.
    // Returns 1 ns after the commit edge.
    task automatic do_out(input logic [7:0] d_first, input logic [7:0] d_last,
                          input int n, input bit push);
        bus.out_req  = 1'b1;
        bus.out_data = {24'hA5C3F0, d_first};
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
        end
        bus.out_data = {24'h000000, d_last};
        if (push) sb.push_back(d_last);
        @(posedge clk); #1;
        bus.out_req  = 1'b0;
        bus.out_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
    endtask

    task automatic wait_fall(input int budget);
        int c = 0;
        while (txd !== 1'b0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("txd_fall", txd, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (!(tx_idle === 1'b1 && sb.size() == 0) && c < budget) begin
            @(posedge clk); #1;
            c++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check_eq("idle_reached", tx_idle, 1'b1);
    endtask

    // txd decoder: samples each bit at mid-cell on the falling clock edge.
    initial begin : monitor
        logic [7:0] rx;
        logic [7:0] exp;
        bit         full;
        forever begin
            @(negedge clk);
            if (mon_en && rstn && txd === 1'b0) begin
                rx   = 8'h00;
                full = 1'b0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (!mon_en) break;
                    if (k == 2) check_eq("start_bit", txd, 1'b0);
                    else if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) rx[(k - 6) / 4] = txd;
                    else if (k == 38) begin
                        check_eq("stop_bit", txd, 1'b1);
                        full = 1'b1;
                    end
                end
                if (full) begin
                    check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check_eq("rx_byte", rx, exp);
                    end
                end
            end
        end
    end

    initial begin
        bus.out_req  = 1'b0;
        bus.out_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_busy", bus.out_busy, 1'b0);
        check_eq("rst_idle", tx_idle, 1'b1);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ovf", overflow, 1'b0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single byte 0x41 and its frame length.
        do_out(8'h41, 8'h41, 1, 1'b1);
        check_eq("commit_count", fifo_count, 1);
        wait_fall(10);
        cnt = 0;
        while (tx_idle !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq("frame_len", cnt, 40);
        wait_idle(100);

        // Request held across a stall: only the last data commits, once.
        do_out(8'h11, 8'h5A, 6, 1'b1);
        peak = int'(fifo_count);
        wait_idle(100);
        check_eq("stall_peak", peak, 1);

        // Fill the FIFO, then commit while full.
        for (int i = 1; i <= 5; i++) begin
            do_out(8'(i), 8'(i), 1, 1'b1);
            if (i == 4) check_eq("busy_at3", bus.out_busy, 1'b0);
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        check_eq("fill_count", fifo_count, 4);
        check_eq("fill_busy", bus.out_busy, 1'b1);
        check_eq("fill_ovf", overflow, 1'b0);
        do_out(8'h66, 8'h66, 1, 1'b0);
        check_eq("ovf_set", overflow, 1'b1);
        check_eq("ovf_count", fifo_count, 4);
        wait_idle(400);
        do_out(8'h77, 8'h77, 1, 1'b1);
        wait_idle(100);
        check_eq("ovf_sticky", overflow, 1'b1);

        // Commit lands on the same edge as the pop of the single queued byte.
        do_out(8'hC3, 8'hC3, 1, 1'b1);
        wait_fall(10);
        do_out(8'h3C, 8'h3C, 1, 1'b1);
        repeat (37) @(posedge clk);
        #1;
        check_eq("simul_pre", fifo_count, 1);
        do_out(8'h96, 8'h96, 1, 1'b1);
        check_eq("simul_count", fifo_count, 1);
        wait_idle(200);

        // Reset during data bit 3 abandons the frame and empties the FIFO.
        do_out(8'hE7, 8'hE7, 1, 1'b1);
        wait_fall(10);
        do_out(8'h81, 8'h81, 1, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        check_eq("rst_pre_count", fifo_count, 1);
        check_eq("rst_pre_txd", txd, 1'b0);
        mon_en = 1'b0;
        rstn   = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_txd", txd, 1'b1);
        check_eq("midrst_count", fifo_count, 0);
        check_eq("midrst_busy", bus.out_busy, 1'b0);
        check_eq("midrst_ovf", overflow, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_out(8'hA5, 8'hA5, 1, 1'b1);
        wait_idle(100);

        repeat (5) @(posedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
